draw_rect_multi: RTL

- Parametrised successor to the single-rectangle drawing stage. Overlays up to N_RECT image rectangles onto the VGA pixel stream.
- Sits after draw_bg and before the output assignment in top_vga.
- Positions and enables are shadowed at the start of vertical blanking, so a frame never tears.
- One pixel-address port drives an external registered image ROM shared by all rectangles; the ROM's return data is keyed against a transparent colour.

---
 rtl/draw_rect_multi.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/draw_rect_multi.sv
// Overlays up to N_RECT image rectangles from a shared registered ROM onto the VGA stream.
// Positions/enables are shadowed on the vblank rising edge; pipeline is hit-detect, ROM read, composite.
module draw_rect_multi #(
  parameter int          N_RECT = 2,
  parameter int          RECT_W = 48,
  parameter int          RECT_H = 64,
  parameter int          ADDR_W = 12,
  parameter logic [11:0] TRANSP = 12'hF0F,
  parameter int          SEL_W  = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [10:0]          hcount_in,
  input  logic                 hsync_in,
  input  logic                 hblnk_in,
  input  logic [10:0]          vcount_in,
  input  logic                 vsync_in,
  input  logic                 vblnk_in,
  input  logic [11:0]          rgb_in,
  input  logic [12*N_RECT-1:0] xpos,
  input  logic [12*N_RECT-1:0] ypos,
  input  logic [N_RECT-1:0]    rect_en,
  input  logic [11:0]          rgb_pixel,
  output logic [ADDR_W-1:0]    pixel_addr,
  output logic [SEL_W-1:0]     rect_sel,
  output logic [10:0]          hcount_out,
  output logic                 hsync_out,
  output logic                 hblnk_out,
  output logic [10:0]          vcount_out,
  output logic                 vsync_out,
  output logic                 vblnk_out,
  output logic [11:0]          rgb_out,
  output logic                 frame_tick
);

  logic [11:0]       shadow_x [N_RECT];
  logic [11:0]       shadow_y [N_RECT];
  logic [N_RECT-1:0] shadow_en;
  logic              vblnk_prev;
  logic              update;

  assign update = vblnk_in && !vblnk_prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vblnk_prev <= 1'b0;
      frame_tick <= 1'b0;
      shadow_en  <= '0;
      for (int i = 0; i < N_RECT; i++) begin
        shadow_x[i] <= '0;
        shadow_y[i] <= '0;
      end
    end else begin
      vblnk_prev <= vblnk_in;
      frame_tick <= update;
      if (update) begin
        shadow_en <= rect_en;
        for (int i = 0; i < N_RECT; i++) begin
          shadow_x[i] <= xpos[12*i +: 12];
          shadow_y[i] <= ypos[12*i +: 12];
        end
      end
    end
  end

  // 13-bit compares keep x+RECT_W from wrapping for positions near 4095.
  logic [12:0]       h13;
  logic [12:0]       v13;
  logic [12:0]       dx [N_RECT];
  logic [12:0]       dy [N_RECT];
  logic [N_RECT-1:0] hit_vec;

  assign h13 = {2'b00, hcount_in};
  assign v13 = {2'b00, vcount_in};

  always_comb begin
    for (int i = 0; i < N_RECT; i++) begin
      dx[i] = h13 - {1'b0, shadow_x[i]};
      dy[i] = v13 - {1'b0, shadow_y[i]};
      hit_vec[i] = shadow_en[i]
                   && (h13 >= {1'b0, shadow_x[i]})
                   && (h13 <= {1'b0, shadow_x[i]} + 13'(RECT_W - 1))
                   && (v13 >= {1'b0, shadow_y[i]})
                   && (v13 <= {1'b0, shadow_y[i]} + 13'(RECT_H - 1));
    end
  end

  logic              any_hit;
  logic [SEL_W-1:0]  win_sel;
  logic [12:0]       win_dx;
  logic [12:0]       win_dy;
  logic [ADDR_W-1:0] win_addr;

  // Scanning from the highest index down lets the lowest hitting index win.
  always_comb begin
    any_hit = 1'b0;
    win_sel = '0;
    win_dx  = '0;
    win_dy  = '0;
    for (int i = N_RECT - 1; i >= 0; i--) begin
      if (hit_vec[i]) begin
        any_hit = 1'b1;
        win_sel = SEL_W'(i);
        win_dx  = dx[i];
        win_dy  = dy[i];
      end
    end
  end

  assign win_addr = ADDR_W'(32'(win_dy) * 32'(RECT_W) + 32'(win_dx));

  logic [10:0] hcount_1, vcount_1, hcount_2, vcount_2;
  logic        hsync_1, hblnk_1, vsync_1, vblnk_1, hit_1;
  logic        hsync_2, hblnk_2, vsync_2, vblnk_2, hit_2;
  logic [11:0] rgb_1, rgb_2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hcount_1   <= '0;
      hsync_1    <= 1'b0;
      hblnk_1    <= 1'b0;
      vcount_1   <= '0;
      vsync_1    <= 1'b0;
      vblnk_1    <= 1'b0;
      rgb_1      <= '0;
      hit_1      <= 1'b0;
      pixel_addr <= '0;
      rect_sel   <= '0;
    end else begin
      hcount_1 <= hcount_in;
      hsync_1  <= hsync_in;
      hblnk_1  <= hblnk_in;
      vcount_1 <= vcount_in;
      vsync_1  <= vsync_in;
      vblnk_1  <= vblnk_in;
      rgb_1    <= rgb_in;
      hit_1    <= any_hit;
      if (any_hit) begin
        pixel_addr <= win_addr;
        rect_sel   <= win_sel;
      end
    end
  end

  // Delay stage running alongside the external ROM's own address register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hcount_2 <= '0;
      hsync_2  <= 1'b0;
      hblnk_2  <= 1'b0;
      vcount_2 <= '0;
      vsync_2  <= 1'b0;
      vblnk_2  <= 1'b0;
      rgb_2    <= '0;
      hit_2    <= 1'b0;
    end else begin
      hcount_2 <= hcount_1;
      hsync_2  <= hsync_1;
      hblnk_2  <= hblnk_1;
      vcount_2 <= vcount_1;
      vsync_2  <= vsync_1;
      vblnk_2  <= vblnk_1;
      rgb_2    <= rgb_1;
      hit_2    <= hit_1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hcount_out <= '0;
      hsync_out  <= 1'b0;
      hblnk_out  <= 1'b0;
      vcount_out <= '0;
      vsync_out  <= 1'b0;
      vblnk_out  <= 1'b0;
      rgb_out    <= '0;
    end else begin
      hcount_out <= hcount_2;
      hsync_out  <= hsync_2;
      hblnk_out  <= hblnk_2;
      vcount_out <= vcount_2;
      vsync_out  <= vsync_2;
      vblnk_out  <= vblnk_2;
      if (hblnk_2 || vblnk_2)
        rgb_out <= 12'h000;
      else if (hit_2 && rgb_pixel != TRANSP)
        rgb_out <= rgb_pixel;
      else
        rgb_out <= rgb_2;
    end
  end

endmodule
